xswitch_req_arbiter: RTL and testbench

- Parametrised request arbiter for the XSwitch crossbar, N_INIT initiators by N_TGT targets.
- Each target has its own arbiter that grants at most one initiator per cycle.
- Adds packet locking: a target stays owned by one initiator from its first beat until the beat flagged last.
- Adds a selectable round-robin or fixed-priority policy.
- Sits between the initiator request decoders and the target-side muxes.

---
 rtl/xswitch_req_arbiter_pkg.sv | 19 +
 rtl/xswitch_req_arbiter_if.sv | 21 ++
 rtl/xswitch_req_arbiter_tgt_arb.sv | 121 ++++++++++++
 rtl/xswitch_req_arbiter.sv | 50 +++++
 tb/tb_xswitch_req_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xswitch_req_arbiter_pkg.sv
// Shared types and helpers for the XSwitch request arbiter.
package xswitch_pkg;

  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_mode_e;

  typedef enum logic {
    TGT_IDLE   = 1'b0,
    TGT_LOCKED = 1'b1
  } tgt_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xswitch_req_arbiter_if.sv
// Request/grant bundle between the initiator decoders and the arbiter.
interface xswitch_req_arbiter_if #(
  parameter int N_INIT = 3,
  parameter int N_TGT  = 5
);
  logic [N_INIT*N_TGT-1:0] i_req;
  logic [N_INIT-1:0]       i_last;
  logic [N_TGT-1:0]        t_rdy;
  logic [N_INIT*N_TGT-1:0] i_vreq;
  logic [N_TGT-1:0]        t_busy;

  modport master (
    output i_req, i_last, t_rdy,
    input  i_vreq, t_busy
  );

  modport slave (
    input  i_req, i_last, t_rdy,
    output i_vreq, t_busy
  );
endinterface

// File: rtl/xswitch_req_arbiter_tgt_arb.sv
// Single-target arbiter: packet lock, owner, round-robin pointer, grant vector.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// TGT_IDLE   | no packet in flight; arbitrate among ready requesters
// TGT_LOCKED | mid-packet; only owner_q may be granted until its last beat
module xswitch_tgt_arb
  import xswitch_pkg::*;
#(
  parameter int N_INIT    = 3,
  parameter int LOCK_EN   = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_INIT-1:0] req_i,
  input  logic [N_INIT-1:0] last_i,
  input  logic              rdy_i,
  output logic [N_INIT-1:0] gnt_o,
  output logic              busy_o
);

  localparam int IW = clog2_min1(N_INIT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_INIT - 1);
  localparam bit FIXED = (PRIO_MODE == int'(PRIO_FIXED));

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  tgt_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [N_INIT-1:0] avail;
  logic [N_INIT-1:0] gnt;
  logic              found;
  logic [IW-1:0]     win;
  logic [IW-1:0]     start;
  logic [IW:0]       sum;
  logic [IW-1:0]     idx;

  assign avail = req_i & {N_INIT{rdy_i}};

  // Find the first available requester, scanning upward from the start index with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    start = FIXED ? '0 : ptr_q;
    for (int k = 0; k < N_INIT; k++) begin
      sum = {1'b0, start} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_INIT)) sum = sum - (IW+1)'(N_INIT);
      idx = sum[IW-1:0];
      if (!found && avail[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state, owner/pointer update and raw grant.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt     = '0;
    case (state_q)
      TGT_IDLE: begin
        if (found) begin
          gnt[win] = 1'b1;
          if (LOCK_EN != 0 && !last_i[win]) begin
            state_d = TGT_LOCKED;
            owner_d = win;
          end else begin
            ptr_d = next_idx(win);
          end
        end
      end
      TGT_LOCKED: begin
        gnt[owner_q] = avail[owner_q];
        if (avail[owner_q] && last_i[owner_q]) begin
          state_d = TGT_IDLE;
          ptr_d   = next_idx(owner_q);
        end
      end
      default: state_d = TGT_IDLE;
    endcase
  end

  // Grants are suppressed while reset is asserted, not just after the next edge.
  assign gnt_o  = rstn ? gnt : '0;
  assign busy_o = (state_q == TGT_LOCKED);

  // State, owner and pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= TGT_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifndef SYNTHESIS
  // Grant sanity: one winner, only ready requesters, owner exclusivity while locked.
  always @(posedge clk) begin
    if (rstn) begin
      assert ($onehot0(gnt_o)) else $error("tgt_arb: grant not onehot0 %b", gnt_o);
      assert ((gnt_o & ~avail) == '0) else $error("tgt_arb: grant without req/rdy %b", gnt_o);
      if (state_q == TGT_LOCKED)
        assert ((gnt_o & ~(N_INIT'(1) << owner_q)) == '0)
          else $error("tgt_arb: non-owner granted while locked %b", gnt_o);
    end
  end
`endif

endmodule

// File: rtl/xswitch_req_arbiter.sv
// Crossbar request arbiter: one xswitch_tgt_arb per target, bit slices transposed here.
module xswitch_req_arbiter
  import xswitch_pkg::*;
#(
  parameter int N_INIT    = 3,
  parameter int N_TGT     = 5,
  parameter int LOCK_EN   = 1,
  parameter int PRIO_MODE = 0
) (
  input logic                 clk,
  input logic                 rstn,
  xswitch_req_arbiter_if.slave bus
);

  for (genvar t = 0; t < N_TGT; t++) begin : g_tgt
    logic [N_INIT-1:0] req_t;
    logic [N_INIT-1:0] gnt_t;

    for (genvar i = 0; i < N_INIT; i++) begin : g_init
      assign req_t[i]                 = bus.i_req[i*N_TGT + t];
      assign bus.i_vreq[i*N_TGT + t]  = gnt_t[i];
    end

    xswitch_tgt_arb #(
      .N_INIT   (N_INIT),
      .LOCK_EN  (LOCK_EN),
      .PRIO_MODE(PRIO_MODE)
    ) u_arb (
      .clk   (clk),
      .rstn  (rstn),
      .req_i (req_t),
      .last_i(bus.i_last),
      .rdy_i (bus.t_rdy[t]),
      .gnt_o (gnt_t),
      .busy_o(bus.t_busy[t])
    );
  end

`ifndef SYNTHESIS
  // Each initiator targets at most one destination per cycle.
  for (genvar i = 0; i < N_INIT; i++) begin : g_chk
    always @(posedge clk) begin
      if (rstn)
        assume ($onehot0(bus.i_req[i*N_TGT +: N_TGT]))
          else $error("arbiter: initiator %0d request not onehot0", i);
    end
  end
`endif

endmodule

// File: tb/tb_xswitch_req_arbiter.sv
// Directed scenarios plus random traffic, checked against a per-target reference model.
module tb_xswitch_req_arbiter;

  localparam int NI = 3;
  localparam int NT = 5;

  logic clk = 1'b0;
  logic rstn;
  logic [NI*NT-1:0] req;
  logic [NI-1:0]    last;
  logic [NT-1:0]    rdy;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = round-robin DUT, 1 = fixed-priority DUT; owner -1 means idle.
  int own [2][NT];
  int ptr [2][NT];
  int s1_order [4] = '{0, 1, 2, 0};

  always #5 clk = ~clk;

  xswitch_req_arbiter_if #(.N_INIT(NI), .N_TGT(NT)) ifc_rr ();
  xswitch_req_arbiter_if #(.N_INIT(NI), .N_TGT(NT)) ifc_fx ();

  assign ifc_rr.i_req  = req;
  assign ifc_rr.i_last = last;
  assign ifc_rr.t_rdy  = rdy;
  assign ifc_fx.i_req  = req;
  assign ifc_fx.i_last = last;
  assign ifc_fx.t_rdy  = rdy;

  xswitch_req_arbiter #(.N_INIT(NI), .N_TGT(NT), .LOCK_EN(1), .PRIO_MODE(0)) dut_rr (
    .clk (clk),
    .rstn(rstn),
    .bus (ifc_rr)
  );

  xswitch_req_arbiter #(.N_INIT(NI), .N_TGT(NT), .LOCK_EN(1), .PRIO_MODE(1)) dut_fx (
    .clk (clk),
    .rstn(rstn),
    .bus (ifc_fx)
  );

  function automatic logic [NI*NT-1:0] bm(int i, int t);
    logic [NI*NT-1:0] v;
    v = '0;
    v[i*NT+t] = 1'b1;
    return v;
  endfunction

  function automatic logic [NI*NT-1:0] exp_vreq(int m);
    logic [NI*NT-1:0] v;
    v = '0;
    if (!rstn) return v;
    for (int t = 0; t < NT; t++) begin
      if (own[m][t] >= 0) begin
        if (req[own[m][t]*NT+t] && rdy[t]) v[own[m][t]*NT+t] = 1'b1;
      end else if (rdy[t]) begin
        int s;
        s = (m == 1) ? 0 : ptr[m][t];
        for (int k = 0; k < NI; k++) begin
          int i;
          i = (s + k) % NI;
          if (req[i*NT+t]) begin
            v[i*NT+t] = 1'b1;
            break;
          end
        end
      end
    end
    return v;
  endfunction

  function automatic logic [NT-1:0] exp_busy(int m);
    logic [NT-1:0] v;
    for (int t = 0; t < NT; t++) v[t] = (own[m][t] >= 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int t = 0; t < NT; t++) begin
        own[m][t] = -1;
        ptr[m][t] = 0;
      end
  endtask

  task automatic model_update(int m, logic [NI*NT-1:0] g);
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NI; i++)
        if (g[i*NT+t]) begin
          if (own[m][t] >= 0) begin
            if (last[i]) begin
              own[m][t] = -1;
              ptr[m][t] = (i + 1) % NI;
            end
          end else if (!last[i]) begin
            own[m][t] = i;
          end else begin
            ptr[m][t] = (i + 1) % NI;
          end
        end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs with the model, then advance one clock and update the model.
  task automatic tick();
    logic [NI*NT-1:0] e0, e1;
    #1;
    e0 = exp_vreq(0);
    e1 = exp_vreq(1);
    chk("vreq_rr", 32'(ifc_rr.i_vreq), 32'(e0));
    chk("vreq_fx", 32'(ifc_fx.i_vreq), 32'(e1));
    chk("busy_rr", 32'(ifc_rr.t_busy), 32'(exp_busy(0)));
    chk("busy_fx", 32'(ifc_fx.t_busy), 32'(exp_busy(1)));
    @(posedge clk);
    if (rstn) begin
      model_update(0, e0);
      model_update(1, e1);
    end
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    req  = '0;
    last = '0;
    rdy  = '1;
    model_reset();
    @(posedge clk);
    #1;

    // Reset: requests present but nothing granted, nothing busy.
    req = bm(0, 0) | bm(1, 0) | bm(2, 0);
    #1;
    chk("rst_vreq", 32'(ifc_rr.i_vreq), 32'd0);
    chk("rst_busy", 32'(ifc_rr.t_busy), 32'd0);
    tick();
    req  = '0;
    rstn = 1'b1;

    // S1: round-robin rotation on T2 with single-beat packets.
    req  = bm(0, 2) | bm(1, 2) | bm(2, 2);
    last = '1;
    rdy  = '1;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("s1_grant", 32'(ifc_rr.i_vreq), 32'(bm(s1_order[n], 2)));
      chk("s1_busy2", 32'(ifc_rr.t_busy[2]), 32'd0);
      tick();
    end

    // Move T0's pointer to I1 with a single-beat I0 packet.
    req  = bm(0, 0);
    last = '1;
    tick();

    // S2: I1 locks T0 for four beats while I0 waits.
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) begin
        req  = bm(0, 0) | bm(1, 0);
        last = (c == 4) ? 3'b111 : 3'b101;
      end else begin
        req  = bm(0, 0);
        last = 3'b111;
      end
      #1;
      chk("s2_grant", 32'(ifc_rr.i_vreq), 32'((c <= 4) ? bm(1, 0) : bm(0, 0)));
      chk("s2_busy0", 32'(ifc_rr.t_busy[0]), 32'((c >= 2 && c <= 4) ? 1 : 0));
      tick();
    end

    // S3: same packet with T0 stalled on cycles 2-3.
    for (int c = 1; c <= 7; c++) begin
      rdy  = {4'b1111, (c == 2 || c == 3) ? 1'b0 : 1'b1};
      req  = (c <= 6) ? (bm(0, 0) | bm(1, 0)) : bm(0, 0);
      last = (c >= 6) ? 3'b111 : 3'b101;
      #1;
      if (c == 2 || c == 3)
        chk("s3_stall", 32'(ifc_rr.i_vreq), 32'd0);
      else
        chk("s3_grant", 32'(ifc_rr.i_vreq), 32'((c <= 6) ? bm(1, 0) : bm(0, 0)));
      chk("s3_busy0", 32'(ifc_rr.t_busy[0]), 32'((c >= 2 && c <= 6) ? 1 : 0));
      tick();
    end

    // S4: independent targets granted in parallel.
    rdy  = '1;
    last = '1;
    req  = bm(0, 1) | bm(1, 3) | bm(2, 4);
    #1;
    chk("s4_rr", 32'(ifc_rr.i_vreq), 32'(bm(0, 1) | bm(1, 3) | bm(2, 4)));
    chk("s4_fx", 32'(ifc_fx.i_vreq), 32'(bm(0, 1) | bm(1, 3) | bm(2, 4)));
    tick();

    // S5: fixed priority always picks I0.
    req = bm(0, 0) | bm(1, 0) | bm(2, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("s5_fx", 32'(ifc_fx.i_vreq), 32'(bm(0, 0)));
      tick();
    end

    // S6: lock T0 to I2, then reset mid-packet.
    req  = bm(2, 0);
    last = '0;
    tick();
    #1;
    chk("s6_locked", 32'(ifc_rr.t_busy[0]), 32'd1);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_busy", 32'(ifc_rr.t_busy), 32'd0);
    chk("s6_rst_vreq", 32'(ifc_rr.i_vreq), 32'd0);
    tick();
    rstn = 1'b1;
    req  = bm(0, 0) | bm(2, 0);
    last = '1;
    #1;
    chk("s6_win", 32'(ifc_rr.i_vreq), 32'(bm(0, 0)));
    tick();

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      req = '0;
      for (int i = 0; i < NI; i++) begin
        int r;
        r = int'($urandom_range(0, NT));
        if (r < NT) req[i*NT+r] = 1'b1;
      end
      last = NI'($urandom);
      rdy  = NT'($urandom) | NT'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rstn = 1'b0;
        model_reset();
        tick();
        rstn = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
